ipf_lcu_feeder: RTL and testbench

- Source end of the filter's pixel input interface (in_en/din/busy/lcu_x/lcu_y/ipf_* fields).
- Reads a 128x128 8-bit image from a synchronous image SRAM and per-LCU filter parameters from a parameter SRAM.
- Streams 64 LCUs of 16x16 in LCU raster order, pixels raster within each LCU, and honours the filter's busy backpressure.
- Reports done when the filter raises finish.

---
 rtl/ipf_pkg.sv | 34 +++
 rtl/ipf_skid_fifo2.sv | 57 +++++
 rtl/ipf_lcu_feeder.sv | 174 +++++++++++++++++
 tb/tb_ipf_lcu_feeder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ipf_pkg.sv
// Shared constants, parameter-word layout, FSM states and image address packing
// for the IPF LCU feeder.
package ipf_pkg;

    localparam int LCU_SIZE     = 16;
    localparam int LOG_SIZE     = 4;
    localparam int IMG_W        = 128;
    localparam int LCU_PIX      = LCU_SIZE * LCU_SIZE;
    localparam int LCUS_PER_ROW = IMG_W / LCU_SIZE;

    localparam int PAR_TYPE_LSB = 22;
    localparam int PAR_BAND_LSB = 17;
    localparam int PAR_WO_BIT   = 16;
    localparam int PAR_OFF_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        PARAM,
        PLOAD,
        STREAM,
        ADV,
        WAITF,
        DONE
    } feeder_state_e;

    // Image is stored row-major, so an LCU pixel lands at {lcu_y,row,lcu_x,col}.
    function automatic logic [13:0] pack_img_addr(input logic [2:0] lcu_y,
                                                   input logic [3:0] row,
                                                   input logic [2:0] lcu_x,
                                                   input logic [3:0] col);
        return {lcu_y, row, lcu_x, col};
    endfunction

endpackage

// File: rtl/ipf_skid_fifo2.sv
// Two-entry, 8-bit skid FIFO that absorbs the image SRAM read latency while
// the filter applies backpressure.
module ipf_skid_fifo2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [1:0] count,
    output logic [7:0] head
);

    logic [7:0] mem0_q, mem0_d;
    logic [7:0] mem1_q, mem1_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            if (wr_ptr_q) begin
                mem1_d = wdata;
            end else begin
                mem0_d = wdata;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = rd_ptr_q ? mem1_q : mem0_q;

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Streams a 128x128 image to the in-loop filter as 64 16x16 LCUs with their
// per-LCU filter parameters, honouring busy backpressure.
module ipf_lcu_feeder
    import ipf_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [13:0] img_addr,
    output logic        img_ren,
    input  logic [7:0]  img_rdata,
    output logic [5:0]  par_addr,
    output logic        par_ren,
    input  logic [23:0] par_rdata,
    input  logic        busy,
    input  logic        finish,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  ipf_type,
    output logic [4:0]  ipf_band_pos,
    output logic        ipf_wo_class,
    output logic [15:0] ipf_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    output logic        done
);

    feeder_state_e state_q, state_d;

    logic [2:0]            lcu_x_q, lcu_x_d;
    logic [2:0]            lcu_y_q, lcu_y_d;
    logic [2*LOG_SIZE:0]   fetch_cnt_q, fetch_cnt_d;
    logic [2*LOG_SIZE-1:0] pix_cnt_q, pix_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            type_q, type_d;
    logic [4:0]            band_q, band_d;
    logic                  wo_q, wo_d;
    logic [15:0]           offset_q, offset_d;
    logic                  done_q, done_d;

    logic [1:0] fifo_count;
    logic [7:0] fifo_head;
    logic       transfer;
    logic       fetch_open;
    logic       issue;
    logic       last_pix;
    logic       last_lcu;

    ipf_skid_fifo2 u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight_q),
        .pop     (transfer),
        .wdata   (img_rdata),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    assign in_en      = (state_q == STREAM) && (fifo_count != 2'd0);
    assign transfer   = in_en && !busy;
    assign fetch_open = (state_q == STREAM) && (fetch_cnt_q != (2*LOG_SIZE+1)'(LCU_PIX));
    // A pop in this cycle frees a slot, which is what sustains one pixel per cycle.
    assign issue      = fetch_open &&
                        (({1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, transfer}) < 3'd2);
    assign last_pix   = transfer && (pix_cnt_q == (2*LOG_SIZE)'(LCU_PIX - 1));
    assign last_lcu   = (lcu_x_q == 3'd7) && (lcu_y_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        lcu_x_d     = lcu_x_q;
        lcu_y_d     = lcu_y_q;
        fetch_cnt_d = fetch_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        inflight_d  = issue;
        type_d      = type_q;
        band_d      = band_q;
        wo_d        = wo_q;
        offset_d    = offset_q;
        done_d      = done_q;
        if (issue) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
        if (transfer) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start) state_d = PARAM;
            end
            PARAM: state_d = PLOAD;
            PLOAD: begin
                type_d   = par_rdata[PAR_TYPE_LSB +: 2];
                band_d   = par_rdata[PAR_BAND_LSB +: 5];
                wo_d     = par_rdata[PAR_WO_BIT];
                offset_d = par_rdata[PAR_OFF_LSB +: 16];
                state_d  = STREAM;
            end
            STREAM: begin
                if (last_pix) begin
                    fetch_cnt_d = '0;
                    state_d     = last_lcu ? WAITF : ADV;
                end
            end
            ADV: begin
                if (lcu_x_q == 3'(LCUS_PER_ROW - 1)) begin
                    lcu_x_d = 3'd0;
                    lcu_y_d = lcu_y_q + 3'd1;
                end else begin
                    lcu_x_d = lcu_x_q + 3'd1;
                end
                state_d = PARAM;
            end
            WAITF: begin
                if (finish) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    done_d  = 1'b0;
                    lcu_x_d = 3'd0;
                    lcu_y_d = 3'd0;
                    state_d = PARAM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lcu_x_q     <= '0;
            lcu_y_q     <= '0;
            fetch_cnt_q <= '0;
            pix_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            type_q      <= '0;
            band_q      <= '0;
            wo_q        <= 1'b0;
            offset_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcu_x_q     <= lcu_x_d;
            lcu_y_q     <= lcu_y_d;
            fetch_cnt_q <= fetch_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            inflight_q  <= inflight_d;
            type_q      <= type_d;
            band_q      <= band_d;
            wo_q        <= wo_d;
            offset_q    <= offset_d;
            done_q      <= done_d;
        end
    end

    assign img_ren      = issue;
    assign img_addr     = pack_img_addr(lcu_y_q, fetch_cnt_q[7:4], lcu_x_q, fetch_cnt_q[3:0]);
    assign par_ren      = (state_q == PARAM);
    assign par_addr     = {lcu_y_q, lcu_x_q};
    assign din          = fifo_head;
    assign ipf_type     = type_q;
    assign ipf_band_pos = band_q;
    assign ipf_wo_class = wo_q;
    assign ipf_offset   = offset_q;
    assign lcu_x        = lcu_x_q;
    assign lcu_y        = lcu_y_q;
    assign lcu_size     = 2'd0;
    assign done         = done_q;

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Scoreboard bench for ipf_lcu_feeder: SRAM models, a frame-level reference
// queue of expected pixels/parameters, and a monitor that pops on every transfer.
module tb_ipf_lcu_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [13:0] img_addr;
    logic        img_ren;
    logic [7:0]  img_rdata;
    logic [5:0]  par_addr;
    logic        par_ren;
    logic [23:0] par_rdata;
    logic        busy;
    logic        finish;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        done;

    typedef struct packed {
        logic [7:0]  pix;
        logic [2:0]  lx;
        logic [2:0]  ly;
        logic [23:0] par;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [23:0] par_mem [64];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          tx_count = 0;
    int          busy_mode = 0;
    int          stall_left = 0;
    bit          stall_done = 0;
    bit          hold_prev = 0;
    logic [63:0] prev_word;
    bit          in_gap = 0;
    int          gap = 0;

    logic [63:0] all_out;
    logic [63:0] cur_word;

    assign all_out  = {img_addr, img_ren, par_addr, par_ren, in_en, din, ipf_type, ipf_band_pos,
                       ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done};
    assign cur_word = {25'd0, in_en, din, lcu_x, lcu_y, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset};

    ipf_lcu_feeder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .img_addr     (img_addr),
        .img_ren      (img_ren),
        .img_rdata    (img_rdata),
        .par_addr     (par_addr),
        .par_ren      (par_ren),
        .par_rdata    (par_rdata),
        .busy         (busy),
        .finish       (finish),
        .in_en        (in_en),
        .din          (din),
        .ipf_type     (ipf_type),
        .ipf_band_pos (ipf_band_pos),
        .ipf_wo_class (ipf_wo_class),
        .ipf_offset   (ipf_offset),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] image_byte(input int addr);
        logic [13:0] a;
        a = 14'(addr);
        return a[7:0] ^ a[13:6];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Synchronous SRAM models with one cycle of read latency.
    always @(posedge clk) begin
        if (img_ren) img_rdata <= image_byte(int'(img_addr));
        if (par_ren) par_rdata <= par_mem[par_addr];
    end

    // Busy driver: optional 5-cycle stall at pixel 37, or 50% random backpressure.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            busy = 1'b1;
            stall_left--;
        end else if (busy_mode == 0 && !stall_done && tx_count == 37 && in_en) begin
            busy = 1'b1;
            stall_left = 4;
            stall_done = 1'b1;
        end else begin
            busy = (busy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: checks each transfer against the scoreboard, the hold rule and the LCU gap.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_prev = 1'b0;
            in_gap    = 1'b0;
        end else begin
            if (hold_prev) checkOutput("busy_hold", cur_word, prev_word);
            if (in_gap) begin
                if (in_en) begin
                    checkOutput($sformatf("lcu_gap_ge3(gap=%0d)", gap), 64'(gap >= 3), 64'd1);
                    in_gap = 1'b0;
                end else begin
                    gap++;
                end
            end
            if (in_en && !busy) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pixel", 64'(in_en), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput($sformatf("pixel%0d", tx_count),
                                64'({din, lcu_x, lcu_y, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}),
                                64'(mon_e));
                end
                if ((tx_count % 256) == 255 && tx_count != 16383) begin
                    in_gap = 1'b1;
                    gap    = 0;
                end
                tx_count++;
            end
            hold_prev = in_en && busy;
            prev_word = cur_word;
        end
    end

    // Fills fresh parameters, queues the whole expected frame, then pulses start.
    task automatic applyStimulus(input int mode);
        exp_t e;
        int   lx, ly, addr;
        for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);
        exp_q.delete();
        tx_count   = 0;
        stall_done = 1'b0;
        busy_mode  = mode;
        for (int l = 0; l < 64; l++) begin
            lx = l % 8;
            ly = l / 8;
            for (int p = 0; p < 256; p++) begin
                addr  = ly * 2048 + (p / 16) * 128 + lx * 16 + (p % 16);
                e.pix = image_byte(addr);
                e.lx  = 3'(lx);
                e.ly  = 3'(ly);
                e.par = par_mem[l];
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic waitDrained(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("frame_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic finishAndCheck();
        repeat (10) @(negedge clk);
        checkOutput("waitf_in_en", 64'(in_en), 64'd0);
        checkOutput("waitf_done", 64'(done), 64'd0);
        @(posedge clk);
        #2 finish = 1'b1;
        @(posedge clk);
        #2 finish = 1'b0;
        @(negedge clk);
        checkOutput("done_set", 64'(done), 64'd1);
        repeat (4) @(negedge clk);
        checkOutput("done_sticky", 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;
        finish    = 1'b0;
        img_rdata = '0;
        par_rdata = '0;
        #1 checkOutput("reset_outputs", all_out, 64'd0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_outputs", all_out, 64'd0);

        $display("[TB] frame 1: no backpressure, stall at pixel 37");
        applyStimulus(0);
        waitDrained(30000);
        finishAndCheck();

        $display("[TB] frame 2: random busy, restart from DONE, early finish ignored");
        applyStimulus(1);
        #1 checkOutput("done_cleared", 64'(done), 64'd0);
        repeat (2000) @(posedge clk);
        #2 finish = 1'b1;
        @(posedge clk);
        #2 finish = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("early_finish_ignored", 64'(done), 64'd0);
        waitDrained(60000);
        finishAndCheck();

        $display("[TB] frame 3: reset at pixel 100 of LCU 5");
        applyStimulus(0);
        n = 0;
        while (tx_count < 5 * 256 + 100 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("reached_lcu5_pix100", 64'(tx_count >= 5 * 256 + 100), 64'd1);
        #3 reset_n = 1'b0;
        exp_q.delete();
        #1 checkOutput("midreset_outputs", all_out, 64'd0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        $display("[TB] frame 4: restart after reset");
        applyStimulus(0);
        waitDrained(30000);
        finishAndCheck();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
